// File: rtl/cdc_2phase_src_arbiter.sv
// Source-domain front end for a clearable 2-phase CDC.
// Arbitrates NUM_REQ requesters round-robin onto the single-bit CDC source
// port and sequences local clears so that the CDC clear input is never
// raised together with valid or while a handshake is open. It also counts
// completed transfers and flags a clear that never completes.
module cdc_2phase_src_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int CNT_WIDTH     = 16,
  parameter int CLEAR_TIMEOUT = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ-1:0]         req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic                       clear_req_i,
  output logic                       clear_busy_o,
  output logic                       cdc_valid_o,
  output logic                       cdc_data_o,
  input  logic                       cdc_ready_i,
  output logic                       cdc_clear_o,
  input  logic                       cdc_clear_pending_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic [CNT_WIDTH-1:0]       xfer_cnt_o,
  output logic                       error_o
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(CLEAR_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    CLEAR_REQ  = 2'd2,
    CLEAR_WAIT = 2'd3
  } state_e;

  state_e               state_q,     state_d;
  logic [IDX_W-1:0]     grant_q,     grant_d;
  logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic                 clr_pend_q,  clr_pend_d;
  logic                 seen_pend_q, seen_pend_d;
  logic [TIMER_W-1:0]   timer_q,     timer_d;
  logic [CNT_WIDTH-1:0] xfer_cnt_q,  xfer_cnt_d;
  logic                 error_q,     error_d;

  // Round-robin pick result.
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  int                   pick_pos;
  logic [IDX_W-1:0]     pick_pos_b;

  // Successor of the current grant, wrapping at NUM_REQ.
  logic [IDX_W-1:0]     grant_next;

  assign grant_next = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  // Find the first valid requester at or after rr_ptr_q, cyclically.
  // Scanning from the far end lets the closest hit overwrite the others.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_pos   = 0;
    pick_pos_b = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pick_pos   = (int'(rr_ptr_q) + i) % NUM_REQ;
      pick_pos_b = IDX_W'(pick_pos);
      if (req_valid_i[pick_pos_b]) begin
        pick_valid = 1'b1;
        pick_idx   = pick_pos_b;
      end
    end
  end

  // Next-state and output decode for the grant/clear sequencer.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    clr_pend_d  = clr_pend_q;
    seen_pend_d = seen_pend_q;
    timer_d     = timer_q;
    xfer_cnt_d  = xfer_cnt_q;
    error_d     = error_q;

    req_ready_o = '0;
    cdc_valid_o = 1'b0;
    cdc_data_o  = 1'b0;
    cdc_clear_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        clr_pend_d = clr_pend_q | clear_req_i;
        if (clr_pend_q | clear_req_i) begin
          // A clear outranks new grants; it waits out any remote clear.
          if (!cdc_clear_pending_i) begin
            state_d = CLEAR_REQ;
          end
        end else if (cdc_clear_pending_i) begin
          // Remote clear isolates the CDC: open no new handshake.
          state_d = IDLE;
        end else if (pick_valid) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end

      BUSY: begin
        // Valid is held until the handshake, even under a latched clear.
        clr_pend_d             = clr_pend_q | clear_req_i;
        cdc_valid_o            = 1'b1;
        cdc_data_o             = req_data_i[grant_q];
        req_ready_o[grant_q]   = cdc_ready_i;
        if (cdc_ready_i) begin
          state_d    = IDLE;
          xfer_cnt_d = xfer_cnt_q + CNT_WIDTH'(1);
          rr_ptr_d   = grant_next;
        end
      end

      CLEAR_REQ: begin
        cdc_clear_o = 1'b1;
        seen_pend_d = 1'b0;
        timer_d     = '0;
        state_d     = CLEAR_WAIT;
      end

      CLEAR_WAIT: begin
        timer_d     = timer_q + TIMER_W'(1);
        seen_pend_d = seen_pend_q | cdc_clear_pending_i;
        if (seen_pend_q && !cdc_clear_pending_i) begin
          // The CDC went through its clear and reopened.
          state_d    = IDLE;
          clr_pend_d = 1'b0;
          xfer_cnt_d = '0;
          rr_ptr_d   = '0;
        end else if (timer_q == TIMER_W'(CLEAR_TIMEOUT - 1)) begin
          // The CDC never acknowledged; give up and keep the counter.
          state_d    = IDLE;
          clr_pend_d = 1'b0;
          error_d    = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      clr_pend_q  <= 1'b0;
      seen_pend_q <= 1'b0;
      timer_q     <= '0;
      xfer_cnt_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      clr_pend_q  <= clr_pend_d;
      seen_pend_q <= seen_pend_d;
      timer_q     <= timer_d;
      xfer_cnt_q  <= xfer_cnt_d;
      error_q     <= error_d;
    end
  end

  assign clear_busy_o = clr_pend_q | (state_q == CLEAR_REQ) | (state_q == CLEAR_WAIT);
  assign grant_idx_o  = grant_q;
  assign xfer_cnt_o   = xfer_cnt_q;
  assign error_o      = error_q;

endmodule

// File: doc/cdc_2phase_src_arbiter.md
# cdc_2phase_src_arbiter

Source-domain controller for one clearable 2-phase CDC. It shares the CDC's single-bit source port among `NUM_REQ` requesters with round-robin arbitration. It also sequences local clear requests so that the CDC clear input is never asserted together with valid or while a handshake is open. It sits in the source clock domain, directly in front of the CDC source port, and counts completed transfers.

## Interface
- `NUM_REQ`, 4: number of requesters; ≥2.
- `CNT_WIDTH`, 16: width of the transfer counter.
- `CLEAR_TIMEOUT`, 1024: maximum cycles spent in `CLEAR_WAIT` before the error flag is raised; ≥4.

Ports:
- `clk_i` in 1: source clock.
- `rst_i` in 1: **asynchronous, active-high reset.**
- `req_valid_i` in NUM_REQ: per-requester valid; must stay high until its ready.
- `req_data_i` in NUM_REQ: per-requester data bit.
- `req_ready_o` out NUM_REQ: per-requester ready; one-hot or zero.
- `clear_req_i` in 1: single-cycle or level request to clear the CDC.
- `clear_busy_o` out 1: a clear is latched or in progress.
- `cdc_valid_o` out 1: to CDC `src_valid_i`.
- `cdc_data_o` out 1: to CDC `src_data_i`.
- `cdc_ready_i` in 1: from CDC `src_ready_o`.
- `cdc_clear_o` out 1: to CDC `src_clear_i`.
- `cdc_clear_pending_i` in 1: from CDC `src_clear_pending_o`.
- `grant_idx_o` out $clog2(NUM_REQ): index of the held grant; valid while `cdc_valid_o`.
- `xfer_cnt_o` out CNT_WIDTH: completed transfers since reset or last clear.
- `error_o` out 1: sticky clear-timeout flag.

## Operation
- States: `IDLE`, `BUSY`, `CLEAR_REQ`, `CLEAR_WAIT`.
- Registers:
  - `state_q`
  - `grant_q`
  - `rr_ptr_q` (highest priority index)
  - `clr_pend_q`
  - `seen_pend_q`
  - `timer_q` (clog2(CLEAR_TIMEOUT+1) bits)
  - `xfer_cnt_q`
  - `error_q`
- `clear_req_i` sets `clr_pend_q` in `IDLE` and `BUSY`. It is ignored in `CLEAR_REQ` and `CLEAR_WAIT`, where the clear already in progress absorbs it.
- `IDLE` transitions, in priority order:
  1. If `clr_pend_q | clear_req_i`:
     - with `!cdc_clear_pending_i`, go to `CLEAR_REQ`;
     - otherwise stay in `IDLE`; the clear is issued once pending drops.
  2. If `cdc_clear_pending_i` is high (remote clear), stay in `IDLE` and issue no grant.
  3. If any `req_valid_i` is set, grant the first set bit at or after `rr_ptr_q`, cyclically. Then `grant_q` ← that index and the next state is `BUSY`.
- `BUSY`:
  - Outputs: `cdc_valid_o`=1, `cdc_data_o`=`req_data_i[grant_q]`, `req_ready_o[grant_q]`=`cdc_ready_i`.
  - On `cdc_ready_i`:
    - go to `IDLE`;
    - `xfer_cnt_q` += 1, wrapping modulo 2^CNT_WIDTH;
    - `rr_ptr_q` ← (grant_q+1) mod NUM_REQ.
  - A latched clear never withdraws valid; it waits for the handshake to complete.
  - If a remote clear isolates the CDC mid-handshake, valid is held and the transfer completes after the CDC reopens.
- `CLEAR_REQ`:
  - Lasts one cycle with `cdc_clear_o`=1 and `cdc_valid_o`=0.
  - Clears `seen_pend_q` and `timer_q`, then goes to `CLEAR_WAIT`.
- `CLEAR_WAIT`:
  - Outputs: `cdc_valid_o`=0; `timer_q` += 1 each cycle.
  - `seen_pend_q` is set when `cdc_clear_pending_i` is high.
  - Completes when `seen_pend_q & !cdc_clear_pending_i`:
    - go to `IDLE`;
    - `clr_pend_q`, `xfer_cnt_q` and `rr_ptr_q` ← 0.
  - Times out when `timer_q == CLEAR_TIMEOUT-1` without completion:
    - `error_q` ← 1, go to `IDLE`;
    - `clr_pend_q` ← 0; the counter is not cleared.
- `clear_busy_o` = `clr_pend_q | state_q` ∈ {`CLEAR_REQ`, `CLEAR_WAIT`}.
- `error_o` is cleared only by `rst_i`.

## Timing
- Reset values:
  - every output is 0, including `grant_idx_o`;
  - state is `IDLE`;
  - every register is 0.
- Grant latency:
  - a valid that is high in an `IDLE` cycle t gives `cdc_valid_o` high at t+1;
  - `req_ready_o` follows `cdc_ready_i` combinationally in the same cycle.
- Throughput: at most one transfer per 2 cycles, because `IDLE` separates grants.
- Clear issue:
  - `clear_req_i` in `IDLE` at t gives `cdc_clear_o` high exactly at t+1, for one cycle;
  - `clear_req_i` in `BUSY` gives `cdc_clear_o` high two cycles after the handshake cycle.
- Invariant: `cdc_clear_o` ⇒ `!cdc_valid_o` on every cycle.
- Simultaneous events:
  - handshake and `clear_req_i` in the same `BUSY` cycle: the transfer is counted, then the clear runs;
  - clear and valids in the same `IDLE` cycle: the clear wins.
- `rst_i` mid-operation: all state returns to reset values immediately, and the open handshake is dropped.

## Test plan
- **Round-robin.** Hold all 4 valids high with `cdc_ready_i` high every `BUSY` cycle. Required: grants 0,1,2,3,0 on cycles 1,3,5,7,9, and `xfer_cnt_o`=4 after cycle 8.
- **Clear during transfer.** Grant requester 2 with `cdc_ready_i` low, pulse `clear_req_i`, then raise `cdc_ready_i` 3 cycles later. Required:
  - `cdc_valid_o` stays high until that handshake;
  - `cdc_clear_o` pulses 2 cycles after the handshake;
  - `clear_busy_o` is high throughout.
- **Clear completion.** Drive `cdc_clear_pending_i` high 1 cycle after `cdc_clear_o` for 6 cycles. Required: `IDLE` in the cycle after pending falls, with `xfer_cnt_o`=0 and `clear_busy_o`=0.
- **Remote clear.** Hold `cdc_clear_pending_i` high with valids present. Required: no grant, and `cdc_valid_o`=0 until pending drops, then a grant on the next cycle.
- **Timeout.** Keep `cdc_clear_pending_i` low after a clear with `CLEAR_TIMEOUT`=8. Required: `error_o`=1 on the 9th cycle after `cdc_clear_o`, and it stays high until `rst_i`.
- **Reset and wrap.** Assert `rst_i` in `BUSY`. Required: all outputs 0 immediately. Also, with `CNT_WIDTH`=2, 5 transfers give `xfer_cnt_o`=1.
